// File: rtl/panda_risc_v_rd_scoreboard.sv
// rtl/panda_risc_v_rd_scoreboard.sv - destination-register scoreboard for long-instruction WAW/RAW hazards (option: PANDA_RISC_V_SB_WB_BYPASS_EN)
module panda_risc_v_rd_scoreboard #(
  parameter int inst_id_width = 4,
  parameter int tbl_depth     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [4:0]                       waw_dpc_check_rd_id,
  output logic                             rd_waw_dpc,
  input  logic [4:0]                       rs1_id,
  input  logic [4:0]                       rs2_id,
  output logic                             rs1_raw_dpc,
  output logic                             rs2_raw_dpc,
  input  logic [4:0]                       alloc_rd_id,
  input  logic [inst_id_width-1:0]         alloc_inst_id,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  input  logic [inst_id_width-1:0]         wb_inst_id,
  input  logic                             wb_valid,
  input  logic                             flush,
  output logic                             tbl_full,
  output logic                             tbl_empty,
  output logic [$clog2(tbl_depth+1)-1:0]   inflight_cnt
);

  localparam int cnt_w = $clog2(tbl_depth + 1);
  localparam int idx_w = (tbl_depth > 1) ? $clog2(tbl_depth) : 1;
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(tbl_depth);

  logic [tbl_depth-1:0]     vld;
  logic [4:0]               rd_tbl [tbl_depth];
  logic [inst_id_width-1:0] id_tbl [tbl_depth];
  logic [cnt_w-1:0]         cnt;

  logic [tbl_depth-1:0]     wb_hit;
  logic [tbl_depth-1:0]     qmask;
  logic [idx_w-1:0]         free_idx;
  logic                     do_alloc;
  logic                     do_dealloc;

  // Find the (at most one) valid entry retired by this cycle's writeback
  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < tbl_depth; i++) begin
      wb_hit[i] = wb_valid & vld[i] & (id_tbl[i] == wb_inst_id);
    end
  end

`ifdef PANDA_RISC_V_SB_WB_BYPASS_EN
  // A retiring entry stops producing hazards in the same cycle
  assign qmask = wb_hit;
`else
  assign qmask = '0;
`endif

  // Query match: any live entry with the same RD; x0 never conflicts
  always_comb begin
    rd_waw_dpc  = 1'b0;
    rs1_raw_dpc = 1'b0;
    rs2_raw_dpc = 1'b0;
    for (int i = 0; i < tbl_depth; i++) begin
      if (vld[i] & ~qmask[i]) begin
        if ((waw_dpc_check_rd_id != 5'd0) && (rd_tbl[i] == waw_dpc_check_rd_id)) rd_waw_dpc = 1'b1;
        if ((rs1_id != 5'd0) && (rd_tbl[i] == rs1_id)) rs1_raw_dpc = 1'b1;
        if ((rs2_id != 5'd0) && (rd_tbl[i] == rs2_id)) rs2_raw_dpc = 1'b1;
      end
    end
  end

  // Lowest-index invalid entry (scan downward so the lowest wins)
  always_comb begin
    free_idx = '0;
    for (int i = tbl_depth - 1; i >= 0; i--) begin
      if (!vld[i]) free_idx = idx_w'(i);
    end
  end

  assign tbl_full     = (cnt == depth_c);
  assign tbl_empty    = (cnt == '0);
  assign alloc_ready  = ~tbl_full;
  assign inflight_cnt = cnt;

  assign do_alloc   = alloc_valid & alloc_ready & (alloc_rd_id != 5'd0);
  assign do_dealloc = |wb_hit;

  // Table and occupancy update; reset and flush clear everything
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < tbl_depth; i++) begin
        if (wb_hit[i]) vld[i] <= 1'b0;
      end
      if (do_alloc) begin
        vld[free_idx]    <= 1'b1;
        rd_tbl[free_idx] <= alloc_rd_id;
        id_tbl[free_idx] <= alloc_inst_id;
      end
      case ({do_alloc, do_dealloc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_panda_risc_v_rd_scoreboard.sv
// tb/tb_panda_risc_v_rd_scoreboard.sv - directed scoreboard bench for panda_risc_v_rd_scoreboard
module tb_panda_risc_v_rd_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] waw_dpc_check_rd_id, rs1_id, rs2_id, alloc_rd_id;
  logic       rd_waw_dpc, rs1_raw_dpc, rs2_raw_dpc;
  logic [3:0] alloc_inst_id, wb_inst_id;
  logic       alloc_valid, alloc_ready, wb_valid, flush;
  logic       tbl_full, tbl_empty;
  logic [2:0] inflight_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       waw;
    logic       rs1;
    logic       rs2;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];

  logic       m_vld [4];
  logic [4:0] m_rd  [4];
  logic [3:0] m_id  [4];

  always #5 clk = ~clk;

  panda_risc_v_rd_scoreboard #(.inst_id_width(4), .tbl_depth(4)) dut (
    .clk(clk), .rst(rst),
    .waw_dpc_check_rd_id(waw_dpc_check_rd_id), .rd_waw_dpc(rd_waw_dpc),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_raw_dpc(rs1_raw_dpc), .rs2_raw_dpc(rs2_raw_dpc),
    .alloc_rd_id(alloc_rd_id), .alloc_inst_id(alloc_inst_id),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .wb_inst_id(wb_inst_id), .wb_valid(wb_valid), .flush(flush),
    .tbl_full(tbl_full), .tbl_empty(tbl_empty), .inflight_cnt(inflight_cnt)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_vld[i]) n++;
    return n;
  endfunction

  function automatic logic model_hit(input logic [4:0] q, input logic wv, input logic [3:0] wid);
    logic h = 1'b0;
    logic masked;
    for (int i = 0; i < 4; i++) begin
      masked = 1'b0;
`ifdef PANDA_RISC_V_SB_WB_BYPASS_EN
      masked = wv && (m_id[i] == wid);
`endif
      if (m_vld[i] && !masked && q != 5'd0 && m_rd[i] == q) h = 1'b1;
    end
    return h;
  endfunction

  // One clock cycle: drive, predict, compare, then advance the model
  task automatic step(input logic av, input logic [4:0] ard, input logic [3:0] aid,
                      input logic wv, input logic [3:0] wid, input logic fl,
                      input logic [4:0] qw, input logic [4:0] q1, input logic [4:0] q2);
    exp_t e, got;
    int   n, fidx, hidx;
    alloc_valid = av; alloc_rd_id = ard; alloc_inst_id = aid;
    wb_valid = wv; wb_inst_id = wid; flush = fl;
    waw_dpc_check_rd_id = qw; rs1_id = q1; rs2_id = q2;
    #1;
    n       = model_cnt();
    e.waw   = model_hit(qw, wv, wid);
    e.rs1   = model_hit(q1, wv, wid);
    e.rs2   = model_hit(q2, wv, wid);
    e.cnt   = 3'(n);
    e.full  = (n == 4);
    e.empty = (n == 0);
    e.ready = (n != 4);
    exp_q.push_back(e);
    got = exp_q.pop_front();
    check("rd_waw_dpc",   {7'd0, rd_waw_dpc},   {7'd0, got.waw});
    check("rs1_raw_dpc",  {7'd0, rs1_raw_dpc},  {7'd0, got.rs1});
    check("rs2_raw_dpc",  {7'd0, rs2_raw_dpc},  {7'd0, got.rs2});
    check("inflight_cnt", {5'd0, inflight_cnt}, {5'd0, got.cnt});
    check("tbl_full",     {7'd0, tbl_full},     {7'd0, got.full});
    check("tbl_empty",    {7'd0, tbl_empty},    {7'd0, got.empty});
    check("alloc_ready",  {7'd0, alloc_ready},  {7'd0, got.ready});
    @(posedge clk);
    fidx = -1; hidx = -1;
    for (int i = 3; i >= 0; i--) if (!m_vld[i]) fidx = i;
    for (int i = 0; i < 4; i++) if (wv && m_vld[i] && m_id[i] == wid) hidx = i;
    if (fl) begin
      for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
    end else begin
      if (hidx >= 0) m_vld[hidx] = 1'b0;
      if (av && n != 4 && ard != 5'd0 && fidx >= 0) begin
        m_vld[fidx] = 1'b1; m_rd[fidx] = ard; m_id[fidx] = aid;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_vld[i] = 1'b0; m_rd[i] = '0; m_id[i] = '0;
    end
    rst = 1'b1; alloc_valid = 0; alloc_rd_id = 0; alloc_inst_id = 0;
    wb_valid = 0; wb_inst_id = 0; flush = 0;
    waw_dpc_check_rd_id = 0; rs1_id = 0; rs2_id = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state, query rd 5
    step(0, 0, 0, 0, 0, 0, 5, 5, 5);
    // allocate rd7 id2, hazard visible next cycle
    step(1, 7, 2, 0, 0, 0, 7, 7, 7);
    step(0, 0, 0, 0, 0, 0, 7, 0, 7);
    check("waw_after_alloc", {7'd0, rd_waw_dpc}, 8'd1);
    // retire id2
    step(0, 0, 0, 1, 2, 0, 7, 7, 7);
    step(0, 0, 0, 0, 0, 0, 7, 7, 7);
    check("waw_after_wb", {7'd0, rd_waw_dpc}, 8'd0);
    // rd 0 never allocates
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("cnt_after_rd0", {5'd0, inflight_cnt}, 8'd0);
    // fill table rd 1..4, ids 0..3
    step(1, 1, 0, 0, 0, 0, 1, 2, 3);
    step(1, 2, 1, 0, 0, 0, 1, 2, 3);
    step(1, 3, 2, 0, 0, 0, 1, 2, 3);
    step(1, 4, 3, 0, 0, 0, 1, 2, 4);
    step(0, 0, 0, 0, 0, 0, 1, 2, 4);
    check("full_after_fill", {7'd0, tbl_full}, 8'd1);
    // allocate while full is ignored
    step(1, 9, 8, 0, 0, 0, 9, 9, 9);
    step(0, 0, 0, 0, 0, 0, 9, 9, 9);
    // allocate + retire id1 while full: allocation dropped
    step(1, 10, 9, 1, 1, 0, 10, 2, 1);
    step(0, 0, 0, 0, 0, 0, 10, 2, 1);
    check("cnt_full_same_cycle", {5'd0, inflight_cnt}, 8'd3);
    // retire id3 to leave 2 valid (ids 0,2)
    step(0, 0, 0, 1, 3, 0, 4, 1, 3);
    // allocate rd6 id5 and retire id0 together
    step(1, 6, 5, 1, 0, 0, 6, 1, 3);
    step(0, 0, 0, 0, 0, 0, 6, 1, 3);
    check("cnt_alloc_dealloc", {5'd0, inflight_cnt}, 8'd2);
    // absent id is ignored
    step(0, 0, 0, 1, 9, 0, 6, 3, 1);
    step(1, 8, 6, 0, 0, 0, 6, 3, 8);
    // flush overrides allocate
    step(1, 11, 7, 0, 0, 1, 6, 3, 8);
    step(0, 0, 0, 0, 0, 0, 6, 3, 11);
    check("empty_after_flush", {7'd0, tbl_empty}, 8'd1);
    // refill after flush still works
    step(1, 12, 1, 0, 0, 0, 12, 0, 12);
    step(0, 0, 0, 0, 0, 0, 12, 0, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
